pos_emb_scheduler: RTL and testbench

- Sequences the positional-embedding (RoPE) datapath across heads, channel-group pairs and tokens.
- Generates one rotate command per (head, half-group, token) tuple. Each command carries the addresses of:
  - the low-half data pixel,
  - the high-half data pixel,
  - the position pixel,
  - both output pixels.
- Throttles commands with a completion-credit counter and signals done when all work has retired.
- Sits between the CSR/launch logic and the PosEmb datapath's HBM read/write engines.

---
 rtl/pos_emb_pkg.sv | 39 +++
 rtl/pos_emb_addr_walker.sv | 89 ++++++++
 rtl/pos_emb_scheduler.sv | 113 +++++++++++
 tb/tb_pos_emb_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pos_emb_pkg.sv
// Shared types and constants for the positional-embedding (RoPE) command scheduler.
package pos_emb_pkg;
  localparam int ADDR_W          = 32;
  localparam int CNT_W           = 12;
  localparam int BEAT_BYTES      = 32;
  localparam int MAX_OUTSTANDING = 8;
  localparam int BEAT_SHIFT      = $clog2(BEAT_BYTES);
  localparam int OST_W           = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [2:0] {IDLE, PREP, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [CNT_W-1:0]  heads;
    logic [CNT_W-1:0]  tokens;
    logic [CNT_W-1:0]  half_groups;
    logic [CNT_W-1:0]  pos_offset;
    logic [ADDR_W-1:0] pos_base;
    logic [ADDR_W-1:0] pos_line_stride;
    logic [ADDR_W-1:0] dat_base;
    logic [ADDR_W-1:0] dat_head_stride;
    logic [ADDR_W-1:0] dat_line_stride;
    logic [ADDR_W-1:0] out_base;
    logic [ADDR_W-1:0] out_head_stride;
    logic [ADDR_W-1:0] out_line_stride;
  } cfg_t;

  typedef struct packed {
    logic [ADDR_W-1:0] dat_lo;
    logic [ADDR_W-1:0] dat_hi;
    logic [ADDR_W-1:0] pos;
    logic [ADDR_W-1:0] out_lo;
    logic [ADDR_W-1:0] out_hi;
    logic              last;
  } cmd_t;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [CNT_W-1:0] n);
    return ADDR_W'(n) << BEAT_SHIFT;
  endfunction
endpackage

// File: rtl/pos_emb_addr_walker.sv
// Head/group/token counters with incrementally maintained command addresses.
module pos_emb_addr_walker
  import pos_emb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic advance,
  input  cfg_t cfg,
  output cmd_t cmd
);
  localparam logic [ADDR_W-1:0] BEAT = ADDR_W'(BEAT_BYTES);

  logic [CNT_W-1:0]  h, g, w;
  logic [ADDR_W-1:0] dat_head, dat_line, dat_lo, dat_hi_off;
  logic [ADDR_W-1:0] out_head, out_line, out_lo, out_hi_off;
  logic [ADDR_W-1:0] pos_start, pos_line, pos_cur;
  logic              w_last, g_last, h_last;
  logic [ADDR_W-1:0] dat_head_nx, dat_line_nx, out_head_nx, out_line_nx, pos_line_nx, pos_init;

  assign w_last = (w == cfg.tokens - CNT_W'(1));
  assign g_last = (g == cfg.half_groups - CNT_W'(1));
  assign h_last = (h == cfg.heads - CNT_W'(1));

  assign dat_head_nx = dat_head + cfg.dat_head_stride;
  assign dat_line_nx = dat_line + cfg.dat_line_stride;
  assign out_head_nx = out_head + cfg.out_head_stride;
  assign out_line_nx = out_line + cfg.out_line_stride;
  assign pos_line_nx = pos_line + cfg.pos_line_stride;
  assign pos_init    = cfg.pos_base + beat_addr(cfg.pos_offset);

  // The only multiplies happen on init (the single PREP cycle); the walk itself is adders only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0; g <= '0; w <= '0;
      dat_head <= '0; dat_line <= '0; dat_lo <= '0; dat_hi_off <= '0;
      out_head <= '0; out_line <= '0; out_lo <= '0; out_hi_off <= '0;
      pos_start <= '0; pos_line <= '0; pos_cur <= '0;
    end else if (init) begin
      h <= '0; g <= '0; w <= '0;
      dat_head   <= cfg.dat_base;
      dat_line   <= cfg.dat_base;
      dat_lo     <= cfg.dat_base;
      dat_hi_off <= ADDR_W'(cfg.half_groups) * cfg.dat_line_stride;
      out_head   <= cfg.out_base;
      out_line   <= cfg.out_base;
      out_lo     <= cfg.out_base;
      out_hi_off <= ADDR_W'(cfg.half_groups) * cfg.out_line_stride;
      pos_start  <= pos_init;
      pos_line   <= pos_init;
      pos_cur    <= pos_init;
    end else if (advance) begin
      if (!w_last) begin
        w       <= w + CNT_W'(1);
        dat_lo  <= dat_lo + BEAT;
        out_lo  <= out_lo + BEAT;
        pos_cur <= pos_cur + BEAT;
      end else if (!g_last) begin
        w        <= '0;
        g        <= g + CNT_W'(1);
        dat_line <= dat_line_nx;
        dat_lo   <= dat_line_nx;
        out_line <= out_line_nx;
        out_lo   <= out_line_nx;
        pos_line <= pos_line_nx;
        pos_cur  <= pos_line_nx;
      end else begin
        w        <= '0;
        g        <= '0;
        h        <= h + CNT_W'(1);
        dat_head <= dat_head_nx;
        dat_line <= dat_head_nx;
        dat_lo   <= dat_head_nx;
        out_head <= out_head_nx;
        out_line <= out_head_nx;
        out_lo   <= out_head_nx;
        pos_line <= pos_start;
        pos_cur  <= pos_start;
      end
    end
  end

  assign cmd.dat_lo = dat_lo;
  assign cmd.dat_hi = dat_lo + dat_hi_off;
  assign cmd.pos    = pos_cur;
  assign cmd.out_lo = out_lo;
  assign cmd.out_hi = out_lo + out_hi_off;
  assign cmd.last   = w_last && g_last && h_last;
endmodule

// File: rtl/pos_emb_scheduler.sv
// RoPE command scheduler: launch FSM, completion-credit throttle and command handshake.
// state | meaning
// IDLE  | waiting for start
// PREP  | one cycle: precompute half offsets and position start, check for empty work
// RUN   | issuing commands under credit limit
// DRAIN | all issued, waiting for outstanding completions
// DONE  | one-cycle done pulse
module pos_emb_scheduler
  import pos_emb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_heads,
  input  logic [CNT_W-1:0]  cfg_tokens,
  input  logic [CNT_W-1:0]  cfg_half_groups,
  input  logic [CNT_W-1:0]  cfg_pos_offset,
  input  logic [ADDR_W-1:0] cfg_pos_base,
  input  logic [ADDR_W-1:0] cfg_pos_line_stride,
  input  logic [ADDR_W-1:0] cfg_dat_base,
  input  logic [ADDR_W-1:0] cfg_dat_head_stride,
  input  logic [ADDR_W-1:0] cfg_dat_line_stride,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic [ADDR_W-1:0] cfg_out_head_stride,
  input  logic [ADDR_W-1:0] cfg_out_line_stride,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_dat_lo_addr,
  output logic [ADDR_W-1:0] cmd_dat_hi_addr,
  output logic [ADDR_W-1:0] cmd_pos_addr,
  output logic [ADDR_W-1:0] cmd_out_lo_addr,
  output logic [ADDR_W-1:0] cmd_out_hi_addr,
  output logic              cmd_last,
  input  logic              cmp_done,
  output logic              busy,
  output logic              done,
  output logic              err_underflow
);
  state_t           state, state_nx;
  cfg_t             cfg_q;
  cmd_t             cmd;
  logic [OST_W-1:0] ost, ost_nx;
  logic             launch, xfer, underflow_evt;

  assign launch = (state == IDLE) && start;
  assign xfer   = cmd_valid && cmd_ready;

  // A completion arriving at the credit limit frees a slot in the same cycle.
  assign cmd_valid = (state == RUN) && ((ost != OST_W'(MAX_OUTSTANDING)) || cmp_done);
  assign underflow_evt = cmp_done && !xfer && (ost == '0);

  always_comb begin
    ost_nx = ost;
    if (xfer && !cmp_done)                   ost_nx = ost + OST_W'(1);
    else if (!xfer && cmp_done && ost != '0) ost_nx = ost - OST_W'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = PREP;
      PREP:  if (cfg_q.heads == '0 || cfg_q.tokens == '0 || cfg_q.half_groups == '0)
               state_nx = DONE;
             else
               state_nx = RUN;
      RUN:   if (xfer && cmd.last) state_nx = DRAIN;
      DRAIN: if (ost_nx == '0) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ost           <= '0;
      err_underflow <= 1'b0;
      cfg_q         <= '0;
    end else begin
      state <= state_nx;
      ost   <= ost_nx;
      if (launch) begin
        err_underflow <= 1'b0;
        cfg_q <= '{heads: cfg_heads, tokens: cfg_tokens, half_groups: cfg_half_groups,
                   pos_offset: cfg_pos_offset, pos_base: cfg_pos_base,
                   pos_line_stride: cfg_pos_line_stride, dat_base: cfg_dat_base,
                   dat_head_stride: cfg_dat_head_stride, dat_line_stride: cfg_dat_line_stride,
                   out_base: cfg_out_base, out_head_stride: cfg_out_head_stride,
                   out_line_stride: cfg_out_line_stride};
      end else if (underflow_evt) begin
        err_underflow <= 1'b1;
      end
    end
  end

  pos_emb_addr_walker u_walker (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (state == PREP),
    .advance (xfer),
    .cfg     (cfg_q),
    .cmd     (cmd)
  );

  assign cmd_dat_lo_addr = cmd.dat_lo;
  assign cmd_dat_hi_addr = cmd.dat_hi;
  assign cmd_pos_addr    = cmd.pos;
  assign cmd_out_lo_addr = cmd.out_lo;
  assign cmd_out_hi_addr = cmd.out_hi;
  assign cmd_last        = cmd.last;
  assign busy            = (state == PREP) || (state == RUN) || (state == DRAIN);
  assign done            = (state == DONE);
endmodule

// File: tb/tb_pos_emb_scheduler.sv
// Self-checking bench for pos_emb_scheduler against an arithmetic address model.
module tb_pos_emb_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] c_heads = '0, c_tokens = '0, c_hg = '0, c_off = '0;
  logic [31:0] c_pos_base = '0, c_pls = '0, c_dat_base = '0, c_dhs = '0, c_dls = '0;
  logic [31:0] c_out_base = '0, c_ohs = '0, c_ols = '0;
  logic        cmd_valid, cmd_ready = 1'b0, cmd_last, cmp_done = 1'b0;
  logic [31:0] dat_lo, dat_hi, pos, out_lo, out_hi;
  logic        busy, done, err_underflow;

  typedef struct packed {
    logic [31:0] lo, hi, pos, olo, ohi;
    logic        last;
  } cmd_s;

  cmd_s exp_q[$];
  cmd_s got_q[$];
  int   vec = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  pos_emb_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_heads(c_heads), .cfg_tokens(c_tokens), .cfg_half_groups(c_hg), .cfg_pos_offset(c_off),
    .cfg_pos_base(c_pos_base), .cfg_pos_line_stride(c_pls),
    .cfg_dat_base(c_dat_base), .cfg_dat_head_stride(c_dhs), .cfg_dat_line_stride(c_dls),
    .cfg_out_base(c_out_base), .cfg_out_head_stride(c_ohs), .cfg_out_line_stride(c_ols),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dat_lo_addr(dat_lo), .cmd_dat_hi_addr(dat_hi), .cmd_pos_addr(pos),
    .cmd_out_lo_addr(out_lo), .cmd_out_hi_addr(out_hi), .cmd_last(cmd_last),
    .cmp_done(cmp_done), .busy(busy), .done(done), .err_underflow(err_underflow)
  );

  function automatic cmd_s sample();
    cmd_s s;
    s = '{lo: dat_lo, hi: dat_hi, pos: pos, olo: out_lo, ohi: out_hi, last: cmd_last};
    return s;
  endfunction

  // Reference: direct closed-form address for every (h, g, w) in loop order.
  task automatic build_exp();
    cmd_s e;
    exp_q.delete();
    for (int h = 0; h < int'(c_heads); h++)
      for (int g = 0; g < int'(c_hg); g++)
        for (int w = 0; w < int'(c_tokens); w++) begin
          e.lo   = c_dat_base + 32'(h) * c_dhs + 32'(g) * c_dls + 32'(w) * 32;
          e.hi   = e.lo + 32'(c_hg) * c_dls;
          e.pos  = c_pos_base + 32'(c_off) * 32 + 32'(g) * c_pls + 32'(w) * 32;
          e.olo  = c_out_base + 32'(h) * c_ohs + 32'(g) * c_ols + 32'(w) * 32;
          e.ohi  = e.olo + 32'(c_hg) * c_ols;
          e.last = (h == int'(c_heads) - 1) && (g == int'(c_hg) - 1) && (w == int'(c_tokens) - 1);
          exp_q.push_back(e);
        end
  endtask

  // Launches one run (cycle 0 = start cycle) and scoreboards every transfer.
  task automatic do_run(input int ready_pct, input int lat, input int budget, input bit scramble);
    int   due_q[$];
    int   idx = 0, first_v = -1, last_x = -1, last_c = -1, done_c = -1;
    bit   pv = 0;
    cmd_s prev = '0, cur;
    build_exp();
    got_q.delete();
    for (int c = 0; c < budget && done_c < 0; c++) begin
      @(negedge clk);
      start     = (c == 0);
      cmd_ready = ($urandom_range(99) < ready_pct);
      cmp_done  = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= c) begin
        void'(due_q.pop_front());
        cmp_done = 1'b1;
        last_c   = c;
      end
      if (scramble && c == 1) begin
        c_dat_base = c_dat_base ^ $urandom();
        c_pls      = c_pls + 32'h40;
        c_tokens   = c_tokens + 12'd1;
      end
      #1;
      cur = sample();
      if (pv) begin
        vec++;
        if (cmd_valid !== 1'b1 || cur !== prev) begin
          errs++;
          $display("FAIL hold_stable c=%0d valid=%b got=%h required=%h", c, cmd_valid, cur, prev);
        end
      end
      if (cmd_valid && first_v < 0) first_v = c;
      if (cmd_valid && cmd_ready) begin
        vec++;
        if (idx >= exp_q.size()) begin
          errs++;
          $display("FAIL extra_cmd idx=%0d got=%h required=none", idx, cur);
        end else if (cur !== exp_q[idx]) begin
          errs++;
          $display("FAIL cmd_fields idx=%0d got=%h required=%h", idx, cur, exp_q[idx]);
        end
        got_q.push_back(cur);
        due_q.push_back(c + lat);
        idx++;
        last_x = c;
      end
      pv   = cmd_valid && !cmd_ready;
      prev = cur;
      if (done) done_c = c;
    end
    @(negedge clk);
    start = 1'b0; cmp_done = 1'b0; cmd_ready = 1'b0;
    vec++;
    if (done_c < 0) begin
      errs++;
      $display("FAIL done_timeout got=none required=done within %0d cycles", budget);
    end else if (done_c != last_c + 1) begin
      errs++;
      $display("FAIL done_timing got=%0d required=%0d", done_c, last_c + 1);
    end
    vec++;
    if (idx != exp_q.size()) begin
      errs++;
      $display("FAIL cmd_count got=%0d required=%0d", idx, exp_q.size());
    end
    vec++;
    if (first_v != 2) begin
      errs++;
      $display("FAIL first_valid got=%0d required=2", first_v);
    end
  endtask

  task automatic set_basic();
    c_heads = 12'd1; c_tokens = 12'd2; c_hg = 12'd2; c_off = 12'd0;
    c_dat_base = 32'h0; c_dhs = 32'h0; c_dls = 32'h400;
    c_pos_base = 32'h0400_0000; c_pls = 32'h100;
    c_out_base = 32'h0800_0000; c_ohs = 32'h0; c_ols = 32'h400;
  endtask

  task automatic test_reset();
    #2;
    vec++;
    if ({cmd_valid, busy, done, err_underflow, cmd_last} !== 5'b0) begin
      errs++;
      $display("FAIL reset_ctrl got=%b required=00000", {cmd_valid, busy, done, err_underflow, cmd_last});
    end
    vec++;
    if ({dat_lo, dat_hi, pos, out_lo, out_hi} !== '0) begin
      errs++;
      $display("FAIL reset_addr got=%h required=0", {dat_lo, dat_hi, pos, out_lo, out_hi});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    set_basic();
    do_run(100, 3, 100, 1'b0);
    vec++;
    if (got_q.size() != 4) begin
      errs++;
      $display("FAIL basic_count got=%0d required=4", got_q.size());
    end else begin
      logic [31:0] lo_ref [4] = '{32'h000, 32'h020, 32'h400, 32'h420};
      logic [31:0] pos_ref[4] = '{32'h400_0000, 32'h400_0020, 32'h400_0100, 32'h400_0120};
      for (int i = 0; i < 4; i++) begin
        vec++;
        if (got_q[i].lo !== lo_ref[i] || got_q[i].hi !== lo_ref[i] + 32'h800 ||
            got_q[i].pos !== pos_ref[i] || got_q[i].last !== (i == 3)) begin
          errs++;
          $display("FAIL basic_cmd%0d got=%h required lo=%h pos=%h", i, got_q[i], lo_ref[i], pos_ref[i]);
        end
      end
    end
  endtask

  task automatic test_head_offset();
    set_basic();
    c_heads = 12'd2; c_dhs = 32'h1000; c_off = 12'd5; c_ohs = 32'h2000;
    do_run(100, 3, 100, 1'b0);
    vec++;
    if (got_q.size() != 8) begin
      errs++;
      $display("FAIL head_count got=%0d required=8", got_q.size());
    end else if (got_q[4].lo !== 32'h1000 || got_q[4].pos !== 32'h400_00A0 || got_q[0].pos !== 32'h400_00A0) begin
      errs++;
      $display("FAIL head1_first got lo=%h pos=%h h0pos=%h required lo=1000 pos=40000a0",
               got_q[4].lo, got_q[4].pos, got_q[0].pos);
    end
  endtask

  task automatic test_back_pressure();
    for (int it = 0; it < 5; it++) begin
      c_heads = 12'($urandom_range(1, 3)); c_tokens = 12'($urandom_range(1, 5));
      c_hg = 12'($urandom_range(1, 3)); c_off = 12'($urandom_range(0, 4095));
      c_pos_base = $urandom(); c_pls = $urandom();
      c_dat_base = $urandom(); c_dhs = $urandom(); c_dls = $urandom();
      c_out_base = $urandom(); c_ohs = $urandom(); c_ols = $urandom();
      do_run(50, $urandom_range(1, 14), 3000, 1'b1);
    end
  endtask

  task automatic test_credit_limit();
    int n = 0;
    set_basic();
    c_tokens = 12'd20; c_hg = 12'd1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = (c == 0); cmd_ready = 1'b1; cmp_done = 1'b0;
      #1;
      if (cmd_valid && cmd_ready) n++;
    end
    vec++;
    if (n != 8 || cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL credit_cap got=%0d valid=%b required=8 valid=0", n, cmd_valid);
    end
    @(negedge clk);
    cmp_done = 1'b1;
    #1;
    vec++;
    if (cmd_valid !== 1'b1) begin
      errs++;
      $display("FAIL credit_same_cycle got=%b required=1", cmd_valid);
    end
    if (cmd_valid && cmd_ready) n++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cmp_done = 1'b0;
      #1;
      if (cmd_valid && cmd_ready) n++;
    end
    vec++;
    if (n != 9) begin
      errs++;
      $display("FAIL credit_one_more got=%0d required=9", n);
    end
    @(negedge clk);
    rst_n = 1'b0; cmd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_config();
    set_basic();
    c_tokens = 12'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    vec++;
    if (busy !== 1'b1 || cmd_valid !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL zero_prep got busy=%b valid=%b done=%b required 1 0 0", busy, cmd_valid, done);
    end
    @(negedge clk); #1;
    vec++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL zero_done got done=%b busy=%b valid=%b required 1 0 0", done, busy, cmd_valid);
    end
    @(negedge clk); #1;
    vec++;
    if (done !== 1'b0 || err_underflow !== 1'b0) begin
      errs++;
      $display("FAIL zero_idle got done=%b err=%b required 0 0", done, err_underflow);
    end
    @(negedge clk); cmp_done = 1'b1;
    @(negedge clk); cmp_done = 1'b0; #1;
    vec++;
    if (err_underflow !== 1'b1) begin
      errs++;
      $display("FAIL underflow_set got=%b required=1", err_underflow);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    vec++;
    if (err_underflow !== 1'b0) begin
      errs++;
      $display("FAIL underflow_clear got=%b required=0", err_underflow);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    set_basic();
    c_tokens = 12'd8;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = (c == 0); cmd_ready = 1'b1; cmp_done = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++;
    if ({cmd_valid, busy, done, err_underflow, cmd_last} !== 5'b0 ||
        {dat_lo, dat_hi, pos, out_lo, out_hi} !== '0) begin
      errs++;
      $display("FAIL midrun_reset got ctrl=%b lo=%h pos=%h required all 0",
               {cmd_valid, busy, done, err_underflow, cmd_last}, dat_lo, pos);
    end
    @(negedge clk);
    rst_n = 1'b1; cmd_ready = 1'b0;
    set_basic();
    do_run(100, 3, 100, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_head_offset();
    test_back_pressure();
    test_credit_limit();
    test_zero_config();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
